mealy_seq_det: RTL and testbench
================================

MEALY_SEQ_DET -- requirements
Module: mealy_seq_det

Interface
REQ-001 Parameter PAT_W, default 4: maximum pattern length in bits, legal range 2..16.
REQ-002 Parameter PAT_DEFAULT, default 4'b1011: pattern value in effect after reset, PAT_W bits wide.
REQ-003 Parameter OVERLAP, default 1: 1 means overlapping matches are counted; 0 means history restarts after each match.
REQ-004 Parameter CNT_W, default 8: width of the match counter.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: reset; one clock; reset is asynchronous and active-high.
REQ-007 Port en, input, 1 bit: when high, din is sampled this cycle.
REQ-008 Port din, input, 1 bit: serial data bit.
REQ-009 Port pat_load, input, 1 bit: when high, load pat_in and len_in.
REQ-010 Port pat_in, input, PAT_W bits: new pattern; bit [len-1] is the first bit received and bit 0 is the last.
REQ-011 Port len_in, input, 5 bits: new active pattern length.
REQ-012 Port dout, output, 1 bit: registered Mealy match pulse.
REQ-013 Port match_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-014 States SHALL be IDLE, RUN and LOAD.
REQ-015 On the first clock after reset release, the FSM SHALL move IDLE->RUN without sampling din, and dout SHALL be 0.
REQ-016 In RUN with en=1, the FSM SHALL shift din into a PAT_W-bit history register, newest bit at [0], and increment fill, saturating at len.
REQ-017 A match SHALL occur when (fill+1)>=len and the low len bits of {history,din} equal the low len bits of the pattern.
REQ-018 Latency: dout SHALL be 1 for exactly one cycle, in the cycle after the clock edge that samples the final pattern bit.
REQ-019 dout SHALL be 0 whenever en=0 or no match occurs.
REQ-020 With en=0 in RUN, history and fill SHALL hold.
REQ-021 With OVERLAP=1, history and fill SHALL continue unchanged after a match.
REQ-022 With OVERLAP=0, fill SHALL clear to 0 on a match, so no bit of a match is reused.
REQ-023 pat_load=1 SHALL take priority over en: the FSM enters LOAD, latches pat_in and len_in, clears history and fill, ignores din, and drives dout=0.
REQ-024 LOAD SHALL return to RUN on the next cycle; pat_load held high SHALL keep the FSM in LOAD and reload each cycle.
REQ-025 len_in of 0, 1 or greater than PAT_W SHALL be stored as PAT_W.
REQ-026 match_cnt SHALL increment by 1 on each match and saturate at 2^CNT_W-1 with no wrap-around.
REQ-027 match_cnt SHALL NOT be cleared by pat_load.
REQ-028 An illegal state encoding SHALL go to IDLE with dout=0.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, dout=0, match_cnt=0, history=0, fill=0, pattern=PAT_DEFAULT, len=PAT_W.
REQ-030 Reset asserted mid-sequence or mid-LOAD SHALL discard all partial progress and any pattern loaded at runtime.

Structure
REQ-031 Package seq_det_pkg SHALL hold the state enumeration (IDLE, RUN, LOAD) and the default constants PAT_W, PAT_DEFAULT and CNT_W.
REQ-032 The saturating counter SHALL be a sub-module seq_det_sat_cnt, parametrised by CNT_W, with inputs clk, rst and inc and output cnt.
REQ-033 The remainder of the design SHALL be a single FSM plus datapath in mealy_seq_det.

Verification
REQ-034 Scenario: defaults, OVERLAP=1, en=1, din 1,0,1,1,0,1,1 -> dout pulses after the 4th bit and after the 7th bit; match_cnt=2.
REQ-035 Scenario: OVERLAP=0, same stream -> exactly one pulse, after the 4th bit; match_cnt=1.
REQ-036 Scenario: pat_load with pat_in=4'b0011 and len_in=2, then din 1,1,1 -> pulses after the 2nd and 3rd bits (overlap mode).
REQ-037 Scenario: en toggled low between the bits 1,0 | 1,1 -> the match still occurs after the 4th enabled bit; dout=0 in every en=0 cycle.
REQ-038 Scenario: CNT_W=2 with 5 matches -> match_cnt sticks at 3.
REQ-039 Scenario: rst pulsed after 1,0,1 have been received -> dout=0 and match_cnt=0; the following 1 does not match; a full 1,0,1,1 after the IDLE cycle matches.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
// Holds the FSM state set, default sizing constants and length clamping.
package seq_det_pkg;

    localparam int         PAT_W       = 4;
    localparam logic [3:0] PAT_DEFAULT = 4'b1011;
    localparam int         CNT_W       = 8;
    localparam int         LEN_W       = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Lengths that cannot describe a useful pattern fall back to the
    // full register width.
    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] l,
        input int               w
    );
        if (int'(l) < 2 || int'(l) > w) begin
            clamp_len = LEN_W'(w);
        end else begin
            clamp_len = l;
        end
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter: counts inc pulses, holds at all-ones.
// Ports: clk, rst (async, active-high), inc, cnt[CNT_W-1:0].
module seq_det_sat_cnt #(
    parameter int CNT_W = seq_det_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mealy_seq_det.sv
// Mealy serial pattern detector with runtime-loadable pattern/length.
// Ports: clk, rst, en, din, pat_load, pat_in, len_in -> dout, match_cnt.
module mealy_seq_det #(
    parameter int               PAT_W       = seq_det_pkg::PAT_W,
    parameter logic [PAT_W-1:0] PAT_DEFAULT =
        PAT_W'(seq_det_pkg::PAT_DEFAULT),
    parameter int               OVERLAP     = 1,
    parameter int               CNT_W       = seq_det_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [4:0]       len_in,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt
);

    import seq_det_pkg::*;

    state_t           state_q;
    state_t           state_d;
    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_d;
    logic [4:0]       fill_q;
    logic [4:0]       fill_d;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] pat_d;
    logic [4:0]       len_q;
    logic [4:0]       len_d;
    logic             dout_q;
    logic             dout_d;
    logic             match;

    logic [PAT_W-1:0] shifted;
    logic [PAT_W-1:0] len_mask;
    logic [4:0]       fill_inc;
    logic             full;
    logic             hit;

    // History as it would look after taking this cycle's bit.
    assign shifted = PAT_W'({hist_q, din});

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Enough bits have arrived (counting the current one) to judge.
    assign full = ({1'b0, fill_q} + 6'd1) >= {1'b0, len_q};

    assign hit = full &&
        (((shifted ^ pat_q) & len_mask) == '0);

    assign fill_inc = (fill_q < len_q) ?
        (fill_q + 5'd1) : fill_q;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        dout_d  = 1'b0;
        match   = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (pat_load) begin
                    state_d = LOAD;
                    pat_d   = pat_in;
                    len_d   = clamp_len(len_in, PAT_W);
                    hist_d  = '0;
                    fill_d  = '0;
                end else if (en) begin
                    hist_d = shifted;
                    fill_d = fill_inc;
                    if (hit) begin
                        match  = 1'b1;
                        dout_d = 1'b1;
                        // Non-overlap mode: matched bits may not
                        // seed the next match.
                        if (OVERLAP == 0) begin
                            fill_d = '0;
                        end
                    end
                end
            end
            LOAD: begin
                if (pat_load) begin
                    state_d = LOAD;
                    pat_d   = pat_in;
                    len_d   = clamp_len(len_in, PAT_W);
                    hist_d  = '0;
                    fill_d  = '0;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PAT_DEFAULT;
            len_q   <= 5'(PAT_W);
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_mealy_seq_det.sv
// Self-checking bench for mealy_seq_det: three instances (overlap,
// non-overlap, 2-bit counter) against a queue-based reference model.
module tb_mealy_seq_det;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'd0;
    logic [4:0] len_in = 5'd0;

    logic       d0, d1, d2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    int checks = 0;
    int errors = 0;
    int sn = 0;

    always #5 clk = ~clk;

    mealy_seq_det dut_ov (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in),
        .dout(d0), .match_cnt(c0)
    );

    mealy_seq_det #(.OVERLAP(0)) dut_no (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in),
        .dout(d1), .match_cnt(c1)
    );

    mealy_seq_det #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in),
        .dout(d2), .match_cnt(c2)
    );

    // Reference model: bits received since the last restart, kept as
    // queues; a match is the tail of the queue equal to the pattern.
    bit         q0[$];
    bit         q1[$];
    bit         q2[$];
    logic [3:0] m_pat;
    int         m_len;
    int         m_mode;   // 0 first cycle after reset, 1 run, 2 load
    int         m_cnt[3];
    bit         m_dout[3];
    int         cap[3] = '{255, 255, 3};

    function automatic bit tail_hit(bit t[$]);
        if (t.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (t[t.size() - m_len + i] != m_pat[m_len - 1 - i])
                return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic credit(input int k, input bit h);
        m_dout[k] = h;
        if (h && m_cnt[k] < cap[k]) m_cnt[k]++;
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete(); q2.delete();
        m_pat = 4'b1011;
        m_len = 4;
        m_mode = 0;
        m_cnt = '{0, 0, 0};
        m_dout = '{0, 0, 0};
    endtask

    task automatic model_load(input logic [3:0] pi, input logic [4:0] li);
        m_pat = pi;
        m_len = (li < 2 || li > 4) ? 4 : int'(li);
        q0.delete(); q1.delete(); q2.delete();
        m_mode = 2;
    endtask

    task automatic model_edge(input bit e, input bit d, input bit pl,
                              input logic [3:0] pi, input logic [4:0] li);
        bit h;
        m_dout = '{0, 0, 0};
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (pl) begin
            model_load(pi, li);
        end else if (m_mode == 2) begin
            m_mode = 1;
        end else if (e) begin
            q0.push_back(d); q1.push_back(d); q2.push_back(d);
            if (q0.size() > 16) void'(q0.pop_front());
            if (q1.size() > 16) void'(q1.pop_front());
            if (q2.size() > 16) void'(q2.pop_front());
            h = tail_hit(q0); credit(0, h);
            h = tail_hit(q1); credit(1, h);
            if (h) q1.delete();
            h = tail_hit(q2); credit(2, h);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string p);
        chk({p, ".dout_ov"}, 32'(d0), 32'(m_dout[0]));
        chk({p, ".dout_no"}, 32'(d1), 32'(m_dout[1]));
        chk({p, ".dout_c2"}, 32'(d2), 32'(m_dout[2]));
        chk({p, ".cnt_ov"}, 32'(c0), 32'(m_cnt[0]));
        chk({p, ".cnt_no"}, 32'(c1), 32'(m_cnt[1]));
        chk({p, ".cnt_c2"}, 32'(c2), 32'(m_cnt[2]));
    endtask

    task automatic step(input bit e, input bit d, input bit pl = 1'b0,
                        input logic [3:0] pi = 4'd0,
                        input logic [4:0] li = 5'd0);
        en = e; din = d; pat_load = pl; pat_in = pi; len_in = li;
        model_edge(e, d, pl, pi, li);
        @(posedge clk);
        #1;
        sn++;
        chk_all($sformatf("step%0d", sn));
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; pat_load = 1'b0;
        #2;
        model_reset();
        chk_all($sformatf("rst_at_step%0d", sn));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    bit s34[7] = '{1, 0, 1, 1, 0, 1, 1};

    initial begin
        #1;
        do_reset();

        // First cycle after reset: din=1 must be ignored.
        step(1, 1);
        foreach (s34[i]) step(1, s34[i]);
        chk("s34.cnt_ov_const", 32'(c0), 32'd2);
        chk("s35.cnt_no_const", 32'(c1), 32'd1);

        // Reset after a partial 1,0,1.
        do_reset();
        step(1, 1);
        step(1, 1); step(1, 0); step(1, 1);
        do_reset();
        chk("s39.cnt_cleared", 32'(c0), 32'd0);
        step(1, 1);
        step(1, 1); step(1, 0); step(1, 1); step(1, 1);
        chk("s39.match_after_idle", 32'(c0), 32'd1);

        // en gaps between 1,0 | 1,1.
        step(0, 1); step(1, 1); step(0, 0); step(1, 0);
        step(0, 1); step(0, 0); step(1, 1); step(0, 0); step(1, 1);

        // Load 2-bit pattern 11, then 1,1,1.
        step(1, 0, 1, 4'b0011, 5'd2);
        step(0, 0);
        step(1, 1); step(1, 1); step(1, 1);

        // Illegal lengths clamp to 4; held load reloads each cycle.
        step(1, 1, 1, 4'b1111, 5'd1);
        step(1, 1, 1, 4'b0110, 5'd0);
        step(0, 0);
        step(1, 0); step(1, 1); step(1, 1); step(1, 0);
        step(1, 0, 1, 4'b1001, 5'd17);
        step(0, 0);
        step(1, 1); step(1, 0); step(1, 0); step(1, 1);

        // Reset in the middle of a load restores the default pattern.
        step(1, 0, 1, 4'b0110, 5'd4);
        do_reset();
        step(1, 0);
        step(1, 1); step(1, 0); step(1, 1); step(1, 1);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 24) == 0,
                     4'($urandom),
                     5'($urandom_range(0, 19)));
            end
        end

        // Counter saturation on the 2-bit instance.
        do_reset();
        step(0, 0);
        step(1, 0, 1, 4'b0011, 5'd2);
        step(0, 0);
        for (int n = 0; n < 8; n++) step(1, 1);
        chk("s38.cnt_c2_sat", 32'(c2), 32'd3);
        chk("s38.cnt_ov_7", 32'(c0), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
